// File: rtl/rect_draw_engine_if.sv
// Draw-command handshake and pixel plot port shared by the game controller and the rectangle fill engine.
// The controller drives the command side; the engine drives the plot side and the busy/done status.
interface rect_draw_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                req;
  logic                cmd_clear;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [X_W-1:0]      cmd_w;
  logic [Y_W-1:0]      cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic                plot;
  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                busy;
  logic                done;

  modport master (
    output req, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  plot, plot_x, plot_y, plot_colour, busy, done
  );

  modport slave (
    input  req, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output plot, plot_x, plot_y, plot_colour, busy, done
  );
endinterface

// File: rtl/rect_draw_engine.sv
// Rectangle fill engine: latches one command, sweeps it row-major at one pixel per clock into the
// plot port with off-screen clipping, then pulses done for one cycle. All outputs are registered.
module rect_draw_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic        clk,
  input  logic        reset,
  rect_draw_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0] CLR_W = X_W'(X_MAX + 1);
  localparam logic [Y_W-1:0] CLR_H = Y_W'(Y_MAX + 1);
  localparam logic [X_W:0]   X_LIM = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] X_ONE = X_W'(1'b1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1'b1);

  state_t              r_state, w_state_nxt;
  logic [X_W-1:0]      r_x0, w_x0_nxt, r_w, w_w_nxt, r_cx, w_cx_nxt;
  logic [Y_W-1:0]      r_y0, w_y0_nxt, r_h, w_h_nxt, r_cy, w_cy_nxt;
  logic [COLOUR_W-1:0] r_colour, w_colour_nxt;
  logic                r_plot, w_plot_nxt, r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic [X_W-1:0]      r_plot_x;
  logic [Y_W-1:0]      r_plot_y;
  logic [COLOUR_W-1:0] r_plot_colour;
  logic [X_W:0]        w_sum_x;
  logic [Y_W:0]        w_sum_y;

  // State, latched command, sweep counters and registered plot outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x0          <= {X_W{1'b0}};
      r_y0          <= {Y_W{1'b0}};
      r_w           <= {X_W{1'b0}};
      r_h           <= {Y_W{1'b0}};
      r_colour      <= {COLOUR_W{1'b0}};
      r_cx          <= {X_W{1'b0}};
      r_cy          <= {Y_W{1'b0}};
      r_plot        <= 1'b0;
      r_plot_x      <= {X_W{1'b0}};
      r_plot_y      <= {Y_W{1'b0}};
      r_plot_colour <= {COLOUR_W{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_x0          <= w_x0_nxt;
      r_y0          <= w_y0_nxt;
      r_w           <= w_w_nxt;
      r_h           <= w_h_nxt;
      r_colour      <= w_colour_nxt;
      r_cx          <= w_cx_nxt;
      r_cy          <= w_cy_nxt;
      r_plot        <= w_plot_nxt;
      r_plot_x      <= w_sum_x[X_W-1:0];
      r_plot_y      <= w_sum_y[Y_W-1:0];
      r_plot_colour <= w_colour_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Next state, next counters and the outputs for the pixel presented in the coming cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_x0_nxt     = r_x0;
    w_y0_nxt     = r_y0;
    w_w_nxt      = r_w;
    w_h_nxt      = r_h;
    w_colour_nxt = r_colour;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_plot_nxt   = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.cmd_clear) begin
            w_x0_nxt = {X_W{1'b0}};
            w_y0_nxt = {Y_W{1'b0}};
            w_w_nxt  = CLR_W;
            w_h_nxt  = CLR_H;
          end else begin
            w_x0_nxt = bus.cmd_x;
            w_y0_nxt = bus.cmd_y;
            w_w_nxt  = bus.cmd_w;
            w_h_nxt  = bus.cmd_h;
          end
          w_colour_nxt = bus.cmd_colour;
          w_cx_nxt     = {X_W{1'b0}};
          w_cy_nxt     = {Y_W{1'b0}};
          if ((w_w_nxt == {X_W{1'b0}}) || (w_h_nxt == {Y_W{1'b0}})) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DRAW;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAW: begin
        // A dropped request abandons the sweep without a done pulse
        if (!bus.req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cx == (r_w - X_ONE)) begin
          w_cx_nxt = {X_W{1'b0}};
          if (r_cy == (r_h - Y_ONE)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cy_nxt = r_cy + Y_ONE;
          end
        end else begin
          w_cx_nxt = r_cx + X_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_sum_x = {1'b0, w_x0_nxt} + {1'b0, w_cx_nxt};
    w_sum_y = {1'b0, w_y0_nxt} + {1'b0, w_cy_nxt};
    if ((w_state_nxt == S_DRAW) && (w_sum_x <= X_LIM) && (w_sum_y <= Y_LIM)) begin
      w_plot_nxt = 1'b1;
    end else begin
      w_plot_nxt = 1'b0;
    end
    if (w_state_nxt != S_IDLE) begin
      w_busy_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
    end
    if (w_state_nxt == S_DONE) begin
      w_done_nxt = 1'b1;
    end else begin
      w_done_nxt = 1'b0;
    end
  end

  assign bus.plot        = r_plot;
  assign bus.plot_x      = r_plot_x;
  assign bus.plot_y      = r_plot_y;
  assign bus.plot_colour = r_plot_colour;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Scoreboard bench for rect_draw_engine: directed commands push cycle-stamped expected plots and
// done pulses; an independent monitor pops and compares every plot/done the engine presents.
module tb_rect_draw_engine;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int col;
    int cyc;
  } exp_t;

  exp_t sb[$];

  rect_draw_if bus ();

  rect_draw_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plot or done seen must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.plot || bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got plot=%0b done=%0b (%0d,%0d) col=%0d, expected nothing",
                 cyc, bus.plot, bus.done, bus.plot_x, bus.plot_y, bus.plot_colour);
      end else begin
        e = sb.pop_front();
        if ((bus.done !== e.is_done) || (bus.plot === bus.done) || (cyc != e.cyc) ||
            (!e.is_done && ((int'(bus.plot_x) != e.x) || (int'(bus.plot_y) != e.y) ||
                            (int'(bus.plot_colour) != e.col)))) begin
          errors++;
          $display("FAIL scoreboard got cyc=%0d plot=%0b done=%0b (%0d,%0d) col=%0d, expected cyc=%0d done=%0b (%0d,%0d) col=%0d",
                   cyc, bus.plot, bus.done, bus.plot_x, bus.plot_y, bus.plot_colour,
                   e.cyc, e.is_done, e.x, e.y, e.col);
        end
      end
    end
  end

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Expected model: row-major sweep from cycle k+1, clipped pixels consume a cycle but emit nothing
  task automatic push_expect(input bit clr, input int x, input int y, input int w, input int h,
                             input int col, input int k, input int max_pix, input bit with_done);
    int n;
    exp_t e;
    if (clr) begin
      x = 0; y = 0; w = 160; h = 120;
    end
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((n < max_pix) && (x + c <= 159) && (y + r <= 119)) begin
          e.is_done = 1'b0; e.x = x + c; e.y = y + r; e.col = col; e.cyc = k + 1 + n;
          sb.push_back(e);
        end
        n++;
      end
    end
    if (with_done) begin
      e.is_done = 1'b1; e.x = 0; e.y = 0; e.col = 0; e.cyc = k + 1 + w * h;
      sb.push_back(e);
    end
  endtask

  task automatic set_cmd(input bit clr, input int x, input int y, input int w, input int h,
                         input int col);
    bus.cmd_clear  = clr;
    bus.cmd_x      = x[7:0];
    bus.cmd_y      = y[6:0];
    bus.cmd_w      = w[7:0];
    bus.cmd_h      = h[6:0];
    bus.cmd_colour = col[2:0];
  endtask

  task automatic start(input bit clr, input int x, input int y, input int w, input int h,
                       input int col, output int k);
    @(posedge clk);
    #1;
    set_cmd(clr, x, y, w, h, col);
    bus.req = 1'b1;
    k = cyc;
  endtask

  // Waits for done with a cycle budget; optionally scrambles command fields mid-command
  task automatic wait_done(input int limit, input bit scramble);
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < limit) && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((i == 0) && scramble) begin
        bus.cmd_clear  = 1'($urandom);
        bus.cmd_x      = 8'($urandom);
        bus.cmd_y      = 7'($urandom);
        bus.cmd_w      = 8'($urandom);
        bus.cmd_h      = 7'($urandom);
        bus.cmd_colour = 3'($urandom);
      end
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done within %0d cycles, expected done", limit);
    end
  endtask

  initial begin
    int k;
    int k2;
    reset   = 1'b1;
    bus.req = 1'b0;
    set_cmd(1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_plot", int'(bus.plot), 0);
    check_eq("reset_plot_x", int'(bus.plot_x), 0);
    check_eq("reset_plot_y", int'(bus.plot_y), 0);
    check_eq("reset_plot_colour", int'(bus.plot_colour), 0);
    check_eq("reset_busy", int'(bus.busy), 0);
    check_eq("reset_done", int'(bus.done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 3x2 rectangle at (10,20), colour 5
    start(1'b0, 10, 20, 3, 2, 5, k);
    push_expect(1'b0, 10, 20, 3, 2, 5, k, 1000000, 1'b1);
    wait_done(50, 1'b1);
    bus.req = 1'b0;

    // Bottom-right corner clipping: 16 sweep cycles, 4 plots
    start(1'b0, 158, 118, 4, 4, 6, k);
    push_expect(1'b0, 158, 118, 4, 4, 6, k, 1000000, 1'b1);
    wait_done(50, 1'b1);
    bus.req = 1'b0;

    // Right-edge clipping with wide rectangle
    start(1'b0, 150, 3, 20, 1, 1, k);
    push_expect(1'b0, 150, 3, 20, 1, 1, k, 1000000, 1'b1);
    wait_done(50, 1'b1);
    bus.req = 1'b0;

    // Full-screen clear ignores the rectangle fields
    start(1'b1, 77, 33, 9, 9, 0, k);
    push_expect(1'b1, 77, 33, 9, 9, 0, k, 1000000, 1'b1);
    wait_done(20000, 1'b1);
    bus.req = 1'b0;

    // Empty height with nonzero width
    start(1'b0, 5, 5, 7, 0, 1, k);
    push_expect(1'b0, 5, 5, 7, 0, 1, k, 1000000, 1'b1);
    wait_done(10, 1'b0);
    bus.req = 1'b0;

    // Empty width, then a back-to-back command with req held across done
    start(1'b0, 40, 50, 0, 5, 7, k);
    push_expect(1'b0, 40, 50, 0, 5, 7, k, 1000000, 1'b1);
    wait_done(10, 1'b0);
    set_cmd(1'b0, 1, 2, 2, 1, 3);
    k2 = cyc + 1;
    check_eq("b2b_start_cycle", k2, k + 2);
    push_expect(1'b0, 1, 2, 2, 1, 3, k2, 1000000, 1'b1);
    wait_done(20, 1'b0);
    bus.req = 1'b0;

    // Reset mid-sweep of a 4x4, then restart with req still high
    start(1'b0, 30, 40, 4, 4, 2, k);
    push_expect(1'b0, 30, 40, 4, 4, 2, k, 5, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    k2 = cyc;
    push_expect(1'b0, 30, 40, 4, 4, 2, k2, 1000000, 1'b1);
    @(negedge clk);
    check_eq("midreset_plot", int'(bus.plot), 0);
    check_eq("midreset_busy", int'(bus.busy), 0);
    check_eq("midreset_done", int'(bus.done), 0);
    wait_done(50, 1'b1);
    bus.req = 1'b0;

    // Abort after 3 pixels of a 5x5
    start(1'b0, 5, 5, 5, 5, 4, k);
    push_expect(1'b0, 5, 5, 5, 5, 4, k, 3, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy", int'(bus.busy), 0);

    repeat (5) @(posedge clk);
    check_eq("scoreboard_leftover", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
